univ_shift_register: RTL and testbench

- Parametrised universal shift register: parallel load, then a burst of identical shift/rotate operations, one per clock, under a start/busy/done handshake.
- Supports logical left/right shift, arithmetic right shift, and left/right rotate by a runtime amount, with serial fill-in and shift-out bit.
- General-purpose datapath building block for serialisers, barrel-style alignment and bit-manipulation sequencers in the SEQUENTIAL library.

---
 rtl/univ_shift_register.sv | 140 ++++++++++++++
 tb/tb_univ_shift_register.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_register.sv
// Universal shift register: parallel load plus a burst of identical shift/rotate
// operations, one per clock, under a start/busy/done handshake.
module univ_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [CNT_W-1:0] reps,
    input  logic             si,
    output logic [WIDTH-1:0] PO,
    output logic             so,
    output logic             busy,
    output logic             done
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [2:0] OpShl = 3'd1;
    localparam logic [2:0] OpShr = 3'd2;
    localparam logic [2:0] OpSra = 3'd3;
    localparam logic [2:0] OpRol = 3'd4;
    localparam logic [2:0] OpRor = 3'd5;

    state_e             r_state, r_state_d;
    logic [WIDTH-1:0]   r_po, r_po_d;
    logic               r_so, r_so_d;
    logic               r_done, r_done_d;
    logic [2:0]         r_op, r_op_d;
    logic [AMT_W-1:0]   r_amt, r_amt_d;
    logic [CNT_W-1:0]   r_cnt, r_cnt_d;

    logic [WIDTH-1:0]   w_fill_lo;
    logic [WIDTH-1:0]   w_fill_hi;
    logic [2*WIDTH-1:0] w_shl_ext;
    logic [2*WIDTH-1:0] w_shr_ext;
    logic [2*WIDTH-1:0] w_rol_ext;
    logic [2*WIDTH-1:0] w_ror_ext;
    logic [AMT_W-1:0]   w_lidx;
    logic [AMT_W-1:0]   w_ridx;

    // Shift a double-width {data, fill} word and keep the relevant half, so a
    // runtime amount fills vacated bits without a per-bit mux.
    assign w_fill_lo = {WIDTH{si}};
    assign w_fill_hi = (r_op == OpSra) ? {WIDTH{r_po[WIDTH-1]}} : {WIDTH{si}};
    assign w_shl_ext = {r_po, w_fill_lo} << r_amt;
    assign w_shr_ext = {w_fill_hi, r_po} >> r_amt;
    assign w_rol_ext = {r_po, r_po} << r_amt;
    assign w_ror_ext = {r_po, r_po} >> r_amt;
    // WIDTH-a modulo WIDTH; only used when a is non-zero
    assign w_lidx    = '0 - r_amt;
    assign w_ridx    = r_amt - AMT_W'(1);

    always_comb begin
        r_state_d = r_state;
        r_po_d    = r_po;
        r_so_d    = r_so;
        r_done_d  = 1'b0;
        r_op_d    = r_op;
        r_amt_d   = r_amt;
        r_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (load) begin
                    r_po_d = load_value;
                end else if (start) begin
                    if (reps == '0) begin
                        r_done_d = 1'b1;
                    end else begin
                        r_op_d    = op;
                        r_amt_d   = amt;
                        r_cnt_d   = reps;
                        r_state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (r_amt != '0) begin
                    case (r_op)
                        OpShl: begin
                            r_po_d = w_shl_ext[2*WIDTH-1:WIDTH];
                            r_so_d = r_po[w_lidx];
                        end
                        OpShr, OpSra: begin
                            r_po_d = w_shr_ext[WIDTH-1:0];
                            r_so_d = r_po[w_ridx];
                        end
                        OpRol: begin
                            r_po_d = w_rol_ext[2*WIDTH-1:WIDTH];
                            r_so_d = r_po[w_lidx];
                        end
                        OpRor: begin
                            r_po_d = w_ror_ext[WIDTH-1:0];
                            r_so_d = r_po[w_ridx];
                        end
                        default: ;
                    endcase
                end
                r_cnt_d = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_state_d = StIdle;
                    r_done_d  = 1'b1;
                end
            end
            default: r_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_po    <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_amt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_d;
            r_po    <= r_po_d;
            r_so    <= r_so_d;
            r_done  <= r_done_d;
            r_op    <= r_op_d;
            r_amt   <= r_amt_d;
            r_cnt   <= r_cnt_d;
        end
    end

    assign PO   = r_po;
    assign so   = r_so;
    assign busy = (r_state == StRun);
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed self-checking bench for univ_shift_register (WIDTH=8).
module tb_univ_shift_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] reps;
    logic       si;
    logic [7:0] PO;
    logic       so;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_register #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .op         (op),
        .amt        (amt),
        .reps       (reps),
        .si         (si),
        .PO         (PO),
        .so         (so),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        tick();
        load       = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] o, input logic [2:0] a, input logic [7:0] n);
        op    = o;
        amt   = a;
        reps  = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Step through a burst, checking PO/so/busy/done after each shift edge.
    task automatic run_steps(input string tag, input int n,
                             input logic [7:0] po_exp [4], input logic so_exp [4]);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_po"}, PO, po_exp[i]);
            check({tag, "_so"}, so, so_exp[i]);
            check({tag, "_busy"}, busy, (i == n - 1) ? 1'b0 : 1'b1);
            check({tag, "_done"}, done, (i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        logic [7:0] pe [4];
        logic       se [4];
        int         seen;

        rst = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
        op = '0; amt = '0; reps = '0; si = 1'b0;

        #3;
        check("rst_po", PO, 8'h00);
        check("rst_so", so, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        tick();
        rst = 1'b1;

        do_load(8'hB4);
        check("load_po", PO, 8'hB4);
        #2 rst = 1'b0;
        #1 check("async_rst_po", PO, 8'h00);
        #1 rst = 1'b1;

        // SRA burst
        do_load(8'h81);
        do_start(3'd3, 3'd1, 8'd3);
        check("sra_busy0", busy, 1'b1);
        check("sra_po0", PO, 8'h81);
        pe = '{8'hC0, 8'hE0, 8'hF0, 8'h00};
        se = '{1'b1, 1'b0, 1'b0, 1'b0};
        run_steps("sra", 3, pe, se);
        tick();
        check("sra_done_drop", done, 1'b0);

        // ROL then back-to-back ROR, started in the done cycle
        do_load(8'h96);
        do_start(3'd4, 3'd3, 8'd1);
        pe = '{8'hB4, 8'h00, 8'h00, 8'h00};
        se = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_steps("rol", 1, pe, se);
        do_start(3'd5, 3'd3, 8'd1);
        check("ror_busy0", busy, 1'b1);
        pe = '{8'h96, 8'h00, 8'h00, 8'h00};
        se = '{1'b1, 1'b0, 1'b0, 1'b0};
        run_steps("ror", 1, pe, se);

        // Serial fill, si=1 then si=0
        si = 1'b1;
        do_load(8'h0F);
        do_start(3'd1, 3'd2, 8'd2);
        pe = '{8'h3F, 8'hFF, 8'h00, 8'h00};
        se = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_steps("shl1", 2, pe, se);
        si = 1'b0;
        do_load(8'h0F);
        do_start(3'd1, 3'd2, 8'd2);
        pe = '{8'h3C, 8'hF0, 8'h00, 8'h00};
        run_steps("shl0", 2, pe, se);

        // reps=0: immediate done, no busy, PO untouched
        tick();
        do_start(3'd1, 3'd1, 8'd0);
        check("rep0_done", done, 1'b1);
        check("rep0_busy", busy, 1'b0);
        check("rep0_po", PO, 8'hF0);
        tick();
        check("rep0_done_drop", done, 1'b0);

        // load during RUN ignored
        do_start(3'd1, 3'd1, 8'd2);
        load = 1'b1;
        load_value = 8'h55;
        tick();
        load = 1'b0;
        check("runload_po1", PO, 8'hE0);
        tick();
        check("runload_po2", PO, 8'hC0);
        check("runload_done", done, 1'b1);

        // load wins over simultaneous start
        load = 1'b1;
        load_value = 8'h55;
        do_start(3'd1, 3'd1, 8'd2);
        load = 1'b0;
        check("ldst_po", PO, 8'h55);
        check("ldst_busy", busy, 1'b0);
        tick();
        check("ldst_po2", PO, 8'h55);
        check("ldst_busy2", busy, 1'b0);
        check("ldst_done2", done, 1'b0);

        // Reset mid-burst
        do_load(8'h80);
        do_start(3'd2, 3'd1, 8'd10);
        repeat (4) tick();
        check("midrst_pre_po", PO, 8'h08);
        #2 rst = 1'b0;
        #1;
        check("midrst_po", PO, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_so", so, 1'b0);
        #2 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done || busy) seen++;
        end
        check("midrst_quiet", seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
